// File: rtl/universal_decoder.sv
// universal_decoder: registered 8-bit code converter (7-seg, one-hot, Gray, ASCII, thermometer, priority); UD_POPCOUNT_EN swaps aux nibble for popcount
module universal_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [7:0] d;
  logic [2:0] mode;
  logic       inv;
  logic [6:0] seg;
  logic [7:0] g2b;
  logic [2:0] idx;
  logic [3:0] n;
  logic [8:0] tw;
  logic       bcd_bad;
  logic [7:0] res;
  logic [7:0] r_next;
  logic       err;
  logic [3:0] ax_next;
  logic [3:0] ax;
  logic       unused;
  assign d       = ui_in;
  assign mode    = uio_in[2:0];
  assign inv     = uio_in[3];
  assign bcd_bad = d[3:0] > 4'd9;
  assign n       = d[3:0] > 4'd8 ? 4'd8 : d[3:0];
  assign tw      = (9'd1 << n) - 9'd1;
  // hex digit to {g,f,e,d,c,b,a}
  always_comb begin
    case (d[3:0])
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
  end
  // each binary bit is the parity of all Gray bits at and above it
  always_comb begin
    g2b = '0;
    for (int i = 0; i < 8; i++) g2b[i] = ^(d >> i);
  end
  // index of the highest set bit; last match wins
  always_comb begin
    idx = '0;
    for (int i = 0; i < 8; i++) if (d[i]) idx = 3'(i);
  end
  // mode select; inversion applies to the 7-segment modes only
  always_comb begin
    res = '0;
    err = 1'b0;
    case (mode)
      3'd0: res = {d[7], seg};
      3'd1: begin
        res = bcd_bad ? 8'h00 : {d[7], seg};
        err = bcd_bad;
      end
      3'd2: res = 8'h01 << d[2:0];
      3'd3: res = g2b;
      3'd4: res = d ^ (d >> 1);
      3'd5: res = bcd_bad ? 8'h37 + {4'h0, d[3:0]} : 8'h30 + {4'h0, d[3:0]};
      3'd6: begin
        res = tw[7:0];
        err = d[3:0] > 4'd8;
      end
      default: begin
        res = d == 8'h00 ? 8'h00 : {5'b10000, idx};
        err = d == 8'h00;
      end
    endcase
    r_next = (inv && mode[2:1] == 2'b00) ? ~res : res;
  end
`ifdef UD_POPCOUNT_EN
  assign ax_next = 4'($countones(d));
`else
  assign ax_next = {err, mode};
`endif
  // capture result and aux on enabled edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uo_out <= '0;
      ax     <= '0;
    end else if (ena) begin
      uo_out <= r_next;
      ax     <= ax_next;
    end
  end
  assign uio_out = {ax, 4'b0000};
  assign uio_oe  = 8'hF0;
  assign unused  = &{1'b0, uio_in[7:4], tw[8], err};
endmodule

// File: tb/tb_universal_decoder.sv
// tb_universal_decoder: randomized and directed checks of universal_decoder against a behavioural model
module tb_universal_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out, uio_out, uio_oe;
  int pass_cnt = 0;
  int total = 0;

  universal_decoder dut (
    .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  // returns {uio_out, uo_out} expected after a capture of (d, m, inv)
  function automatic logic [15:0] model(input logic [7:0] d, input logic [2:0] m, input logic inv);
    logic [7:0] hex [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    int lo = int'(d[3:0]);
    int nn;
    int cnt = 0;
    logic [7:0] r = '0;
    logic err = 1'b0;
    logic acc = 1'b0;
    logic [3:0] ax;
    case (m)
      3'd0: r = {d[7], hex[lo][6:0]};
      3'd1: if (lo <= 9) r = {d[7], hex[lo][6:0]}; else err = 1'b1;
      3'd2: r = 8'(1 << int'(d[2:0]));
      3'd3: for (int i = 7; i >= 0; i--) begin acc = acc ^ d[i]; r[i] = acc; end
      3'd4: r = d ^ (d >> 1);
      3'd5: r = 8'(lo <= 9 ? 48 + lo : 65 + lo - 10);
      3'd6: begin nn = lo > 8 ? 8 : lo; r = 8'((1 << nn) - 1); err = lo > 8; end
      default: if (d == 0) err = 1'b1; else r = 8'(128 + $clog2(int'(d) + 1) - 1);
    endcase
    if (inv && m < 2) r = ~r;
    for (int i = 0; i < 8; i++) cnt += int'(d[i]);
`ifdef UD_POPCOUNT_EN
    ax = 4'(cnt);
`else
    ax = {err, m};
`endif
    return {ax, 4'h0, r};
  endfunction

  task automatic drive(input logic [7:0] d, input logic [2:0] m, input logic inv, input logic en);
    ui_in = d;
    uio_in = {4'($urandom_range(0, 15)), inv, m};
    ena = en;
  endtask

  task automatic test_reset;
    #2;
    total++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'hF0)
      $display("FAIL reset_async: got uo=%h uio=%h oe=%h want 00 00 F0", uo_out, uio_out, uio_oe);
    else pass_cnt++;
    drive(8'h8A, 3'd0, 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    total++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00)
      $display("FAIL reset_release: got uo=%h uio=%h want 00 00", uo_out, uio_out);
    else pass_cnt++;
    @(posedge clk); #1;
    total++;
    if (uo_out !== 8'hF7) $display("FAIL first_edge: got %h want F7", uo_out);
    else pass_cnt++;
  endtask

  typedef struct { logic [7:0] d; logic [2:0] m; logic inv; logic [7:0] r; logic [3:0] ax_def; } vec_t;

  task automatic test_directed;
    vec_t v [13] = '{
      '{8'h8A, 3'd0, 1'b0, 8'hF7, 4'h0}, '{8'h8A, 3'd0, 1'b1, 8'h08, 4'h0},
      '{8'h0C, 3'd1, 1'b0, 8'h00, 4'h9}, '{8'h0C, 3'd1, 1'b1, 8'hFF, 4'h9},
      '{8'h05, 3'd1, 1'b0, 8'h6D, 4'h1}, '{8'h24, 3'd7, 1'b0, 8'h85, 4'h7},
      '{8'h00, 3'd7, 1'b0, 8'h00, 4'hF}, '{8'hC0, 3'd3, 1'b0, 8'h80, 4'h3},
      '{8'h0B, 3'd4, 1'b1, 8'h0E, 4'h4}, '{8'h03, 3'd6, 1'b0, 8'h07, 4'h6},
      '{8'h0F, 3'd6, 1'b0, 8'hFF, 4'hE}, '{8'h0E, 3'd5, 1'b1, 8'h45, 4'h5},
      '{8'h07, 3'd2, 1'b0, 8'h80, 4'h2}};
    logic [15:0] e;
    foreach (v[k]) begin
      drive(v[k].d, v[k].m, v[k].inv, 1'b1);
      @(posedge clk); #1;
      e = model(v[k].d, v[k].m, v[k].inv);
      total++;
      if (uo_out !== v[k].r) $display("FAIL directed_r[%0d]: got %h want %h", k, uo_out, v[k].r);
      else pass_cnt++;
      total++;
`ifdef UD_POPCOUNT_EN
      if (uio_out !== e[15:8]) $display("FAIL directed_ax[%0d]: got %h want %h", k, uio_out, e[15:8]);
`else
      if (uio_out !== {v[k].ax_def, 4'h0}) $display("FAIL directed_ax[%0d]: got %h want %h", k, uio_out, {v[k].ax_def, 4'h0});
`endif
      else pass_cnt++;
    end
  endtask

  task automatic test_hold;
    logic [15:0] e;
    drive(8'hF1, 3'd4, 1'b0, 1'b1);
    @(posedge clk); #1;
    e = model(8'hF1, 3'd4, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(8'($urandom), 3'($urandom), 1'($urandom), 1'b0);
      @(posedge clk); #1;
      total++;
      if ({uio_out, uo_out} !== e) $display("FAIL hold[%0d]: got %h want %h", k, {uio_out, uo_out}, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_random;
    logic [15:0] e;
    logic [7:0] d;
    logic [2:0] m;
    logic inv, en;
    e = {uio_out, uo_out};
    for (int k = 0; k < 300; k++) begin
      d = 8'($urandom); m = 3'($urandom); inv = 1'($urandom); en = $urandom_range(0, 3) != 0;
      drive(d, m, inv, en);
      @(posedge clk); #1;
      if (en) e = model(d, m, inv);
      total++;
      if ({uio_out, uo_out} !== e || uio_oe !== 8'hF0)
        $display("FAIL random[%0d]: d=%h m=%0d inv=%b got %h oe=%h want %h", k, d, m, inv, {uio_out, uo_out}, uio_oe, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid;
    drive(8'h24, 3'd7, 1'b0, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    total++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00) $display("FAIL reset_mid: got uo=%h uio=%h want 00 00", uo_out, uio_out);
    else pass_cnt++;
    rst = 1'b0;
    ena = 1'b0;
    @(posedge clk); #1;
    total++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00) $display("FAIL reset_discard: got uo=%h uio=%h want 00 00", uo_out, uio_out);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_hold;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
